// File: rtl/mdio_phy_responder.sv
// PHY-side Clause 45 MDIO responder: oversamples MDC, decodes frames for PHY_ADDR/DEV_ADDR, serves a small register file.
// Optional: define MDIO_CLAUSE22_EN to also accept Clause 22 (ST=01) read/write frames.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR    = 5'd0,
    parameter logic [4:0] DEV_ADDR    = 5'd1,
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdio_o,
    output logic mdio_t,
    output logic frame_done,
    output logic frame_err
);
    typedef enum logic [2:0] {PRE, ST, OP, PRTAD, DEVAD, TA, DATA, SKIP} state_t;

    logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
    logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
    logic        mdc_prev_q, mdc_prev_d;
    logic        mdc_rise_q, mdc_rise_d;
    logic        mdio_s_q, mdio_s_d;
    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  op_q, op_d;
    logic        c22_q, c22_d;
    logic        match_q, match_d;
    logic [4:0]  fld_q, fld_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] addr_q, addr_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;

    logic        wr_en;
    logic [15:0] wr_data, eff_addr, rd_data, shift_in;
    logic [15:0] regs_rd [NUM_REGS];
    logic [4:0]  fld_next;
    logic [1:0]  op_next;
    logic        is_read, is_write, is_addr, is_incr;

    assign shift_in = {shift_q[14:0], mdio_s_q};
    assign fld_next = {fld_q[3:0], mdio_s_q};
    assign op_next  = {op_q[0], mdio_s_q};
    assign wr_data  = shift_in;

    // Clause 22 frames carry the register number directly in the REGAD field.
    assign is_read  = c22_q ? (op_q == 2'b10) : op_q[1];
    assign is_write = (op_q == 2'b01);
    assign is_addr  = !c22_q && (op_q == 2'b00);
    assign is_incr  = !c22_q && (op_q == 2'b10);
    assign eff_addr = c22_q ? {11'd0, fld_q} : addr_q;

    always_comb begin
        rd_data = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (eff_addr == 16'(i)) rd_data = regs_rd[i];
        end
    end

    always_comb begin
        mdc_sync_d   = {mdc_sync_q[SYNC_STAGES-2:0], mdc};
        mdio_sync_d  = {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
        mdc_prev_d   = mdc_sync_q[SYNC_STAGES-1];
        mdc_rise_d   = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
        mdio_s_d     = mdio_sync_q[SYNC_STAGES-1];
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        op_d         = op_q;
        c22_d        = c22_q;
        match_d      = match_q;
        fld_d        = fld_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        mdio_o_d     = mdio_o_q;
        mdio_t_d     = mdio_t_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;
        if (mdc_rise_q) begin
            case (state_q)
                PRE: begin
                    if (mdio_s_q) begin
                        pre_cnt_d = (pre_cnt_q == 6'd32) ? 6'd32 : pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == 6'd32) begin
                        pre_cnt_d = '0;
                        state_d   = ST;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                ST: begin
                    bit_cnt_d = '0;
                    if (!mdio_s_q) begin
                        c22_d   = 1'b0;
                        state_d = OP;
                    end else begin
`ifdef MDIO_CLAUSE22_EN
                        c22_d   = 1'b1;
                        state_d = OP;
`else
                        frame_err_d = 1'b1;
                        pre_cnt_d   = '0;
                        state_d     = PRE;
`endif
                    end
                end
                OP: begin
                    op_d      = op_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = '0;
                        state_d   = PRTAD;
                        if (c22_q && (op_next == 2'b00 || op_next == 2'b11)) begin
                            frame_err_d = 1'b1;
                            pre_cnt_d   = '0;
                            state_d     = PRE;
                        end
                    end
                end
                PRTAD: begin
                    fld_d     = fld_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        match_d   = (fld_next == PHY_ADDR);
                        bit_cnt_d = '0;
                        state_d   = DEVAD;
                    end
                end
                DEVAD: begin
                    fld_d     = fld_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        if (!c22_q) match_d = match_q && (fld_next == DEV_ADDR);
                        bit_cnt_d = '0;
                        state_d   = match_d ? TA : SKIP;
                    end
                end
                TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                        if (is_read) begin
                            shift_d  = rd_data;
                            mdio_t_d = 1'b0;
                            mdio_o_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                        if (is_read) begin
                            mdio_o_d = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (is_read) begin
                        mdio_o_d = shift_q[15];
                        shift_d  = {shift_q[14:0], 1'b0};
                    end else begin
                        shift_d = shift_in;
                    end
                    if (bit_cnt_q == 5'd15) begin
                        frame_done_d = 1'b1;
                        bit_cnt_d    = '0;
                        pre_cnt_d    = '0;
                        state_d      = PRE;
                        mdio_t_d     = 1'b1;
                        mdio_o_d     = 1'b0;
                        if (is_addr)  addr_d = shift_in;
                        if (is_write) wr_en  = 1'b1;
                        if (is_incr)  addr_d = addr_q + 16'd1;
                    end
                end
                SKIP: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd17) begin
                        bit_cnt_d = '0;
                        pre_cnt_d = '0;
                        state_d   = PRE;
                    end
                end
                default: begin
                    pre_cnt_d = '0;
                    state_d   = PRE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mdc_sync_q   <= '0;
            mdio_sync_q  <= '1;
            mdc_prev_q   <= 1'b0;
            mdc_rise_q   <= 1'b0;
            mdio_s_q     <= 1'b1;
            state_q      <= PRE;
            pre_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            op_q         <= '0;
            c22_q        <= 1'b0;
            match_q      <= 1'b0;
            fld_q        <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            mdio_o_q     <= 1'b0;
            mdio_t_q     <= 1'b1;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            mdc_sync_q   <= mdc_sync_d;
            mdio_sync_q  <= mdio_sync_d;
            mdc_prev_q   <= mdc_prev_d;
            mdc_rise_q   <= mdc_rise_d;
            mdio_s_q     <= mdio_s_d;
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            op_q         <= op_d;
            c22_q        <= c22_d;
            match_q      <= match_d;
            fld_q        <= fld_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            mdio_o_q     <= mdio_o_d;
            mdio_t_q     <= mdio_t_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Out-of-range writes match no register and are silently dropped.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [15:0] reg_q;
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    reg_q <= '0;
                end else if (wr_en && (eff_addr == 16'(gi))) begin
                    reg_q <= wr_data;
                end
            end
            assign regs_rd[gi] = reg_q;
        end
    endgenerate

    assign mdio_o     = mdio_o_q;
    assign mdio_t     = mdio_t_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
endmodule
